// File: rtl/iddr_rx_pkg.sv
// Shared types and constants for the DDR nibble-bus frame receiver.
package iddr_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    DATA      = 3'd3,
    DROP      = 3'd4
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         CNT_W         = 11;

endpackage

// File: rtl/iddr_frame_rx_capture.sv
// Dual-edge capture of rxd/rx_ctl, retimed so both halves of a byte land on the same posedge.
module iddr_capture #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rxd,
  input  logic             rx_ctl,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             dv,
  output logic             er,
  output logic             cap_valid
);

  logic [WIDTH:0]   pin_d;
  logic [WIDTH:0]   rise_q;
  logic [WIDTH:0]   fall_q;
  logic [WIDTH-1:0] q1_d, q1_q;
  logic [WIDTH-1:0] q2_d, q2_q;
  logic             dv_d, dv_q;
  logic             er_d, er_q;
  logic [1:0]       vld_d, vld_q;

  always_comb begin
    pin_d = {rx_ctl, rxd};
    q1_d  = rise_q[WIDTH-1:0];
    q2_d  = fall_q[WIDTH-1:0];
    dv_d  = rise_q[WIDTH];
    er_d  = rise_q[WIDTH] ^ fall_q[WIDTH];
    // cap_valid rises once both capture stages hold real pad samples after reset
    vld_d = {vld_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
      dv_q   <= 1'b0;
      er_q   <= 1'b0;
      vld_q  <= '0;
    end else begin
      rise_q <= pin_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      dv_q   <= dv_d;
      er_q   <= er_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) fall_q <= '0;
    else        fall_q <= pin_d;
  end

  assign q1        = q1_q;
  assign q2        = q2_q;
  assign dv        = dv_q;
  assign er        = er_q;
  assign cap_valid = vld_q[1];

endmodule

// File: rtl/iddr_frame_rx.sv
// DDR frame receiver: strips preamble/SFD and emits payload bytes with sof/last/err.
// Optional frame statistics are built when IDDR_RX_STATS_EN is defined.
module iddr_frame_rx
  import iddr_rx_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 1522
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   rxd,
  input  logic               rx_ctl,
  output logic [WIDTH-1:0]   q1,
  output logic [WIDTH-1:0]   q2,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_valid,
  output logic               m_sof,
  output logic               m_last,
  output logic               m_err,
  output logic [15:0]        stat_good,
  output logic [15:0]        stat_bad
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  logic [1:0] rst_sync_d, rst_sync_q;
  logic       rst_sync_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_sync_n = rst_sync_q[1];

  logic dv, er, cap_valid;

  iddr_capture #(.WIDTH(WIDTH)) u_capture (
    .clk       (clk),
    .rst_n     (rst_sync_n),
    .rxd       (rxd),
    .rx_ctl    (rx_ctl),
    .q1        (q1),
    .q2        (q2),
    .dv        (dv),
    .er        (er),
    .cap_valid (cap_valid)
  );

  logic [2*WIDTH-1:0] b;
  assign b = {q2, q1};

  rx_state_e          state_d, state_q;
  logic [2*WIDTH-1:0] hold_d, hold_q;
  logic               have_d, have_q;
  logic               first_d, first_q;
  logic               err_acc_d, err_acc_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [2*WIDTH-1:0] m_data_d, m_data_q;
  logic               m_valid_d, m_valid_q;
  logic               m_sof_d, m_sof_q;
  logic               m_last_d, m_last_q;
  logic               m_err_d, m_err_q;
  logic               good_evt, bad_evt;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    have_d    = have_q;
    first_d   = first_q;
    err_acc_d = err_acc_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    m_sof_d   = 1'b0;
    m_last_d  = 1'b0;
    m_err_d   = 1'b0;
    good_evt  = 1'b0;
    bad_evt   = 1'b0;
    case (state_q)
      WAIT_IDLE: if (cap_valid && !dv) state_d = IDLE;
      IDLE: begin
        if (dv) state_d = (b == PREAMBLE_BYTE && !er) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (er) begin
          state_d = DROP;
        end else if (b == SFD_BYTE) begin
          state_d   = DATA;
          cnt_d     = '0;
          have_d    = 1'b0;
          first_d   = 1'b1;
          err_acc_d = 1'b0;
        end else if (b != PREAMBLE_BYTE) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!dv) begin
          state_d = IDLE;
          have_d  = 1'b0;
          if (have_q) begin
            m_data_d  = hold_q;
            m_valid_d = 1'b1;
            m_sof_d   = first_q;
            m_last_d  = 1'b1;
            m_err_d   = err_acc_q;
            good_evt  = !err_acc_q;
            bad_evt   = err_acc_q;
          end else begin
            bad_evt = 1'b1;
          end
        end else if (cnt_q == MAX_CNT) begin
          // a byte beyond MAX_LEN arrived: close the frame on the held byte as truncated
          state_d   = DROP;
          have_d    = 1'b0;
          m_data_d  = hold_q;
          m_valid_d = 1'b1;
          m_sof_d   = first_q;
          m_last_d  = 1'b1;
          m_err_d   = 1'b1;
          bad_evt   = 1'b1;
        end else begin
          if (have_q) begin
            m_data_d  = hold_q;
            m_valid_d = 1'b1;
            m_sof_d   = first_q;
            first_d   = 1'b0;
          end
          hold_d    = b;
          have_d    = 1'b1;
          err_acc_d = err_acc_q | er;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      DROP: if (!dv) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= WAIT_IDLE;
      hold_q    <= '0;
      have_q    <= 1'b0;
      first_q   <= 1'b0;
      err_acc_q <= 1'b0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      have_q    <= have_d;
      first_q   <= first_d;
      err_acc_q <= err_acc_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_sof_q   <= m_sof_d;
      m_last_q  <= m_last_d;
      m_err_q   <= m_err_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_sof   = m_sof_q;
  assign m_last  = m_last_q;
  assign m_err   = m_err_q;

`ifdef IDDR_RX_STATS_EN
  logic [15:0] good_d, good_q;
  logic [15:0] bad_d, bad_q;

  always_comb begin
    good_d = (good_evt && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
    bad_d  = (bad_evt && bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign stat_good = good_q;
  assign stat_bad  = bad_q;
`else
  logic unused_stats;
  assign unused_stats = good_evt | bad_evt;
  assign stat_good    = '0;
  assign stat_bad     = '0;
`endif

endmodule
